// File: rtl/lru_trace_pkg.sv
// Shared widths and the trace record layout for the LRU request receiver.
package lru_trace_pkg;
  localparam int TAG_W  = 17;
  localparam int IDX_W  = 11;
  localparam int INST_W = 21;
  localparam int RX_CNT_W   = 32;
  localparam int DROP_CNT_W = 16;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  index;
    logic              store;
    logic [INST_W-1:0] inst;
  } lru_rec_t;
endpackage

// File: rtl/lru_rec_fifo.sv
// First-word-fall-through FIFO of trace records; the head is held in a register
// so the outputs keep their last value once the FIFO drains.
import lru_trace_pkg::*;

module lru_rec_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  lru_rec_t                 din,
  output logic                     push_ack,
  input  logic                     pop,
  output lru_rec_t                 dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  lru_rec_t          mem [DEPTH];
  logic [AW-1:0]     wptr, rptr, rptr_nx;
  logic [AW:0]       level_nx;
  logic              valid_q, do_pop, do_push;

  assign empty    = !valid_q;
  assign full     = (level == (AW+1)'(DEPTH));
  assign do_pop   = pop && valid_q;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
  assign do_push  = push && (!full || do_pop);
  assign push_ack = do_push;
  assign rptr_nx  = rptr + AW'(do_pop);

  always_comb begin
    level_nx = level;
    if (do_push && !do_pop)      level_nx = level + 1'b1;
    else if (do_pop && !do_push) level_nx = level - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      level   <= '0;
      valid_q <= 1'b0;
      dout    <= '0;
    end else begin
      wptr    <= wptr + AW'(do_push);
      rptr    <= rptr_nx;
      level   <= level_nx;
      valid_q <= (level_nx != '0);
      // Next head is either already stored or being written this cycle.
      if (level_nx != '0)
        dout <= (do_push && (wptr == rptr_nx)) ? din : mem[rptr_nx];
    end
  end
endmodule

// File: rtl/lru_req_rx.sv
// Trace-record receiver: strobe detect, FWFT buffering, rx/drop statistics.
// Define LRU_REQ_RX_SEQ_CHECK_EN to enable the instruction-sequence gap counter.
import lru_trace_pkg::*;

module lru_req_rx #(
  parameter int DEPTH     = 8,
  parameter int TAG_W     = lru_trace_pkg::TAG_W,
  parameter int IDX_W     = lru_trace_pkg::IDX_W,
  parameter int INST_W    = lru_trace_pkg::INST_W,
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [TAG_W-1:0]       LRUTag,
  input  logic [IDX_W-1:0]       LRUIndex,
  input  logic                   LRULoadStore,
  input  logic [INST_W-1:0]      LRUInst,
  input  logic                   LRULineReady,
  output logic                   req_valid,
  input  logic                   req_ready,
  output logic [TAG_W-1:0]       req_tag,
  output logic [IDX_W-1:0]       req_index,
  output logic                   req_store,
  output logic [INST_W-1:0]      req_inst,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [31:0]            rx_count,
  output logic [15:0]            drop_count,
  output logic                   overflow,
  output logic [15:0]            seq_err_count
);
  logic     strobe_q, cap, push_ack, full, empty, drop;
  lru_rec_t rec, head;

  assign cap = EDGE_MODE ? (LRULineReady && !strobe_q) : LRULineReady;
  assign rec = '{tag: LRUTag, index: LRUIndex, store: LRULoadStore, inst: LRUInst};

  lru_rec_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (cap),
    .din      (rec),
    .push_ack (push_ack),
    .pop      (req_ready),
    .dout     (head),
    .full     (full),
    .empty    (empty),
    .level    (fifo_level)
  );

  assign req_valid = !empty;
  assign req_tag   = head.tag;
  assign req_index = head.index;
  assign req_store = head.store;
  assign req_inst  = head.inst;
  assign drop      = cap && !push_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      strobe_q   <= 1'b0;
      rx_count   <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
    end else begin
      strobe_q <= LRULineReady;
      if (push_ack) rx_count <= rx_count + 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
      end
    end
  end

`ifdef LRU_REQ_RX_SEQ_CHECK_EN
  logic [INST_W-1:0] exp_inst;
  logic              seen_first;

  // Drops leave exp_inst stale, so the record after a drop flags a gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_inst      <= '0;
      seen_first    <= 1'b0;
      seq_err_count <= '0;
    end else if (push_ack) begin
      exp_inst   <= LRUInst + 1'b1;
      seen_first <= 1'b1;
      if (seen_first && (LRUInst != exp_inst) && (seq_err_count != 16'hFFFF))
        seq_err_count <= seq_err_count + 1'b1;
    end
  end
`else
  assign seq_err_count = '0;
`endif
endmodule
